// File: rtl/pc_fetch_unit_pkg.sv
// Shared CPU definitions: fetch-state encoding and next-PC select codes.
package pc_fetch_unit_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned MC_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_BOOT   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } fetch_state_e;

    typedef enum logic [MC_W-1:0] {
        MC_SEQ = 2'b00,
        MC_BRC = 2'b01,
        MC_JMP = 2'b10,
        MC_BRU = 2'b11
    } mc_sel_e;

    // A live execute-stage instruction requests a taken branch or jump.
    function automatic logic is_redirect(input logic          valid_2,
                                         input logic [MC_W-1:0] mc,
                                         input logic          br_cond);
        return valid_2 & ((mc == MC_BRU) | (mc == MC_JMP) |
                          ((mc == MC_BRC) & br_cond));
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Execute/decode side signals of the fetch unit, grouped as one bus.
interface pc_fetch_unit_if #(
    parameter int unsigned WIDTH = 32
);
    import pc_fetch_unit_pkg::*;

    logic                stall;
    logic [MC_W-1:0]     mc;
    logic                br_cond;
    logic [WIDTH-1:0]    BrA;
    logic [WIDTH-1:0]    raa;
    logic                halt;
    logic [WIDTH-1:0]    pc;
    logic [WIDTH-1:0]    pc_1;
    logic [WIDTH-1:0]    pc_2;
    logic                valid_1;
    logic                valid_2;
    logic                fetch_en;
    logic                redirect;
    logic                halted;

    // CPU pipeline side: issues requests, observes fetch state.
    modport master (
        output stall, mc, br_cond, BrA, raa, halt,
        input  pc, pc_1, pc_2, valid_1, valid_2, fetch_en, redirect, halted
    );

    // Fetch unit side.
    modport slave (
        input  stall, mc, br_cond, BrA, raa, halt,
        output pc, pc_1, pc_2, valid_1, valid_2, fetch_en, redirect, halted
    );

endinterface

// File: rtl/pc_fetch_unit_pc_next_mux.sv
// Next-PC selection: PC+1, branch target or register jump target.
module pc_next_mux
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_pc,
    input  logic [WIDTH-1:0] i_bra,
    input  logic [WIDTH-1:0] i_raa,
    input  logic [MC_W-1:0]  i_mc,
    input  logic             i_br_cond,
    input  logic             i_valid_2,
    output logic [WIDTH-1:0] o_pc_next,
    output logic             o_redirect
);

    logic w_redirect;

    // Redirect only for live execute instructions; PC+1 wraps naturally.
    always_comb begin
        w_redirect = is_redirect(i_valid_2, i_mc, i_br_cond);
        o_pc_next  = i_pc + WIDTH'(1);
        if (w_redirect) begin
            if (mc_sel_e'(i_mc) == MC_JMP) begin
                o_pc_next = i_raa;
            end else begin
                o_pc_next = i_bra;
            end
        end
    end

    assign o_redirect = w_redirect;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC register and PC/valid tracking down to decode and execute.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned     WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    pc_fetch_unit_if.slave  bus
);

    fetch_state_e     r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_pc_1;
    logic [WIDTH-1:0] r_pc_2;
    logic             r_valid_1;
    logic             r_valid_2;
    logic             r_halted;

    logic [WIDTH-1:0] w_pc_next;
    logic             w_redirect;
    logic             w_halt_req;

    pc_next_mux #(
        .WIDTH (WIDTH)
    ) u_pc_next_mux (
        .i_pc      (r_pc),
        .i_bra     (bus.BrA),
        .i_raa     (bus.raa),
        .i_mc      (bus.mc),
        .i_br_cond (bus.br_cond),
        .i_valid_2 (r_valid_2),
        .o_pc_next (w_pc_next),
        .o_redirect(w_redirect)
    );

    // Halt counts only when the execute slot is live.
    assign w_halt_req = r_valid_2 & bus.halt;

    // State machine and pipeline registers; priority halt > redirect > stall > sequential.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_BOOT;
            r_pc      <= RESET_PC;
            r_pc_1    <= '0;
            r_pc_2    <= '0;
            r_valid_1 <= 1'b0;
            r_valid_2 <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_halt_req) begin
                        r_state   <= ST_HALTED;
                        r_halted  <= 1'b1;
                        r_valid_1 <= 1'b0;
                        r_valid_2 <= 1'b0;
                    end else if (w_redirect) begin
                        r_pc      <= w_pc_next;
                        r_pc_1    <= r_pc;
                        r_pc_2    <= r_pc_1;
                        r_valid_1 <= 1'b0;
                        r_valid_2 <= 1'b0;
                    end else if (bus.stall) begin
                        r_pc_2    <= r_pc_1;
                        r_valid_2 <= 1'b0;
                    end else begin
                        r_pc      <= w_pc_next;
                        r_pc_1    <= r_pc;
                        r_valid_1 <= 1'b1;
                        r_pc_2    <= r_pc_1;
                        r_valid_2 <= r_valid_1;
                    end
                end
                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    assign bus.pc       = r_pc;
    assign bus.pc_1     = r_pc_1;
    assign bus.pc_2     = r_pc_2;
    assign bus.valid_1  = r_valid_1;
    assign bus.valid_2  = r_valid_2;
    assign bus.halted   = r_halted;
    assign bus.redirect = w_redirect;
    assign bus.fetch_en = (r_state == ST_RUN) & (~bus.stall | w_redirect);

endmodule
